// File: rtl/kmeans_sched.sv
// Iteration sequencer for the k-means engine: config read, assign/update passes, final copy.
// Optional watchdog on the engine wait states is enabled with KMEANS_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module kmeans_sched #(
    parameter int ADDR_NB  = 15,
    parameter int DATA_NB  = 16,
    parameter int MAX_ITER = 100,
    parameter int MAX_VALS = 2048
`ifdef KMEANS_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 2**20
`endif
) (
    input  logic               Clk,
    input  logic               RESET,
    input  logic               start,
    output logic               ready,
    output logic               done,
    output logic               err,
    output logic               converged,
    output logic [6:0]         iter_count,
    output logic [ADDR_NB-1:0] bram_addr,
    input  logic [DATA_NB-1:0] bram_din,
    output logic [DATA_NB-1:0] num_vals,
    output logic [DATA_NB-1:0] num_clusters,
    output logic [DATA_NB-1:0] num_dims,
    output logic               assign_start,
    input  logic               assign_done,
    input  logic               assign_changed,
    output logic               update_start,
    input  logic               update_done,
    output logic               copy_start,
    input  logic               copy_done
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_CFG0 = 4'd1,
        RD_CFG1 = 4'd2,
        RD_CFG2 = 4'd3,
        RD_CFG3 = 4'd4,
        CHK     = 4'd5,
        A_WAIT  = 4'd6,
        U_WAIT  = 4'd7,
        C_WAIT  = 4'd8,
        FIN     = 4'd9
    } state_t;

    state_t state;
    logic   cfg_bad_s;
    logic   last_pass_s;
    logic   timeout_s;
    logic [6:0] iter_next_s;

    assign cfg_bad_s = (num_clusters == {DATA_NB{1'b0}}) || (num_dims == {DATA_NB{1'b0}}) ||
                       (num_vals == {DATA_NB{1'b0}}) || (num_clusters > num_vals) ||
                       (num_vals > DATA_NB'(MAX_VALS));
    assign iter_next_s = (iter_count < 7'(MAX_ITER)) ? (iter_count + 7'd1) : iter_count;
    assign last_pass_s = (iter_next_s == 7'(MAX_ITER));

`ifdef KMEANS_SCHED_TIMEOUT_EN
    logic [20:0] wdog;
    logic [20:0] wdog_idx_s;
    logic        in_wait_s;

    // Every wait-state entry coincides with its start pulse, so the pulse marks cycle zero.
    assign in_wait_s  = (state == A_WAIT) || (state == U_WAIT) || (state == C_WAIT);
    assign wdog_idx_s = (assign_start || update_start || copy_start) ? 21'd0 : wdog;
    assign timeout_s  = in_wait_s && (wdog_idx_s == 21'(TIMEOUT_CYC - 1));

    // Watchdog counter: cycles spent in the current wait state.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            wdog <= 21'd0;
        end else begin
            wdog <= wdog_idx_s + 21'd1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Sequencer FSM with registered outputs; start/done pulses default low each cycle.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            ready        <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            converged    <= 1'b0;
            iter_count   <= 7'd0;
            bram_addr    <= {ADDR_NB{1'b0}};
            num_vals     <= {DATA_NB{1'b0}};
            num_clusters <= {DATA_NB{1'b0}};
            num_dims     <= {DATA_NB{1'b0}};
            assign_start <= 1'b0;
            update_start <= 1'b0;
            copy_start   <= 1'b0;
        end else begin
            done         <= 1'b0;
            assign_start <= 1'b0;
            update_start <= 1'b0;
            copy_start   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ready      <= 1'b0;
                        err        <= 1'b0;
                        converged  <= 1'b0;
                        iter_count <= 7'd0;
                        bram_addr  <= {ADDR_NB{1'b0}};
                        state      <= RD_CFG0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                RD_CFG0: begin
                    bram_addr <= ADDR_NB'(2'd1);
                    state     <= RD_CFG1;
                end
                RD_CFG1: begin
                    num_vals  <= bram_din;
                    bram_addr <= ADDR_NB'(2'd2);
                    state     <= RD_CFG2;
                end
                RD_CFG2: begin
                    num_clusters <= bram_din;
                    bram_addr    <= {ADDR_NB{1'b0}};
                    state        <= RD_CFG3;
                end
                RD_CFG3: begin
                    num_dims <= bram_din;
                    state    <= CHK;
                end
                CHK: begin
                    if (cfg_bad_s) begin
                        err       <= 1'b1;
                        converged <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        assign_start <= 1'b1;
                        state        <= A_WAIT;
                    end
                end
                A_WAIT: begin
                    if (assign_done) begin
                        iter_count <= iter_next_s;
                        // The seed pass never counts as converged; its centroids are not real means.
                        if (!assign_changed && (iter_count >= 7'd1)) begin
                            converged  <= 1'b1;
                            copy_start <= 1'b1;
                            state      <= C_WAIT;
                        end else if (last_pass_s) begin
                            converged  <= 1'b0;
                            copy_start <= 1'b1;
                            state      <= C_WAIT;
                        end else begin
                            update_start <= 1'b1;
                            state        <= U_WAIT;
                        end
                    end else if (timeout_s) begin
                        err       <= 1'b1;
                        converged <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        state <= A_WAIT;
                    end
                end
                U_WAIT: begin
                    if (update_done) begin
                        assign_start <= 1'b1;
                        state        <= A_WAIT;
                    end else if (timeout_s) begin
                        err       <= 1'b1;
                        converged <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        state <= U_WAIT;
                    end
                end
                C_WAIT: begin
                    if (copy_done) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (timeout_s) begin
                        err       <= 1'b1;
                        converged <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        state <= C_WAIT;
                    end
                end
                FIN: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_sched.sv
// Self-checking bench for kmeans_sched: BRAM and engine responders with random latency,
// expected pass counts derived from the iteration rules.
`timescale 1ns/1ps
module tb_kmeans_sched;
    localparam int ADDR_NB  = 15;
    localparam int DATA_NB  = 16;
    localparam int MAX_ITER = 100;
    localparam int MAX_VALS = 2048;

    logic               Clk = 1'b0;
    logic               RESET = 1'b1;
    logic               start = 1'b0;
    logic               ready, done, err, converged;
    logic [6:0]         iter_count;
    logic [ADDR_NB-1:0] bram_addr;
    logic [DATA_NB-1:0] bram_din = 16'h0000;
    logic [DATA_NB-1:0] num_vals, num_clusters, num_dims;
    logic               assign_start, update_start, copy_start;
    logic               assign_done = 1'b0, assign_changed = 1'b0;
    logic               update_done = 1'b0, copy_done = 1'b0;

    logic [DATA_NB-1:0] mem [0:3];
    bit  chg_tab [0:MAX_ITER-1];
    bit  hold_upd = 1'b0;
    int  job_id = 0;
    int  n_as = 0, n_us = 0, n_cs = 0, n_done = 0;
    int  n_cmp = 0, n_fail = 0;

    kmeans_sched dut (
        .Clk(Clk), .RESET(RESET), .start(start), .ready(ready), .done(done), .err(err),
        .converged(converged), .iter_count(iter_count), .bram_addr(bram_addr), .bram_din(bram_din),
        .num_vals(num_vals), .num_clusters(num_clusters), .num_dims(num_dims),
        .assign_start(assign_start), .assign_done(assign_done), .assign_changed(assign_changed),
        .update_start(update_start), .update_done(update_done),
        .copy_start(copy_start), .copy_done(copy_done)
    );

    always #5 Clk = ~Clk;

    // Registered BRAM: one-cycle read latency.
    always @(posedge Clk) bram_din <= mem[bram_addr[1:0]];

    always @(negedge Clk) begin
        if (assign_start === 1'b1) n_as++;
        if (update_start === 1'b1) n_us++;
        if (copy_start === 1'b1) n_cs++;
        if (done === 1'b1) n_done++;
    end

    // Assign engine: replies after 0..3 cycles with the scripted changed flag.
    initial begin : resp_assign
        int d, pidx, my_job;
        my_job = -1; pidx = 0;
        forever begin
            @(posedge Clk); #1;
            if (assign_start === 1'b1) begin
                if (job_id != my_job) begin my_job = job_id; pidx = 0; end
                d = $urandom_range(0, 3);
                if (d != 0) begin repeat (d) @(posedge Clk); #1; end
                assign_changed = chg_tab[(pidx < MAX_ITER) ? pidx : MAX_ITER - 1];
                pidx++;
                assign_done = 1'b1;
                @(posedge Clk); #1;
                assign_done = 1'b0;
                assign_changed = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : resp_update
        int d;
        forever begin
            @(posedge Clk); #1;
            if (update_start === 1'b1 && !hold_upd) begin
                d = $urandom_range(0, 3);
                if (d != 0) begin repeat (d) @(posedge Clk); #1; end
                update_done = 1'b1;
                @(posedge Clk); #1;
                update_done = 1'b0;
            end
        end
    end

    initial begin : resp_copy
        int d;
        forever begin
            @(posedge Clk); #1;
            if (copy_start === 1'b1) begin
                d = $urandom_range(0, 3);
                if (d != 0) begin repeat (d) @(posedge Clk); #1; end
                copy_done = 1'b1;
                @(posedge Clk); #1;
                copy_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: passes run until a non-seed pass reports no change or the pass limit is hit.
    task automatic model(input int nv, input int nc, input int nd,
                         output int e_as, output int e_us, output int e_cs,
                         output int e_conv, output int e_iter, output int e_err);
        e_as = 0; e_us = 0; e_cs = 0; e_conv = 0; e_iter = 0; e_err = 0;
        if (nc == 0 || nd == 0 || nv == 0 || nc > nv || nv > MAX_VALS) begin
            e_err = 1;
        end else begin
            for (int p = 1; p <= MAX_ITER; p++) begin
                e_iter = p; e_as = p; e_us = p - 1; e_cs = 1;
                if (p >= 2 && !chg_tab[p - 1]) begin
                    e_conv = 1;
                    break;
                end
            end
        end
    endtask

    task automatic fill_chg(input int pct_one);
        for (int i = 0; i < MAX_ITER; i++) chg_tab[i] = ($urandom_range(0, 99) < pct_one);
    endtask

    task automatic run_job(input string tag, input int nv, input int nc, input int nd, input bit extra);
        int e_as, e_us, e_cs, e_conv, e_iter, e_err, as0, us0, cs0, cyc;
        bit sent;
        model(nv, nc, nd, e_as, e_us, e_cs, e_conv, e_iter, e_err);
        mem[0] = 16'(nv); mem[1] = 16'(nc); mem[2] = 16'(nd); mem[3] = 16'hDEAD;
        job_id++;
        as0 = n_as; us0 = n_us; cs0 = n_cs;
        @(posedge Clk); #1;
        check({tag, ":ready_idle"}, ready, 1);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        @(negedge Clk); check({tag, ":addr0"}, bram_addr, 0); check({tag, ":ready_busy"}, ready, 0);
        @(negedge Clk); check({tag, ":addr1"}, bram_addr, 1);
        @(negedge Clk); check({tag, ":addr2"}, bram_addr, 2);
        cyc = 0; sent = 1'b0;
        while (done !== 1'b1 && cyc < 4000) begin
            @(negedge Clk); cyc++;
            if (extra && !sent && assign_start === 1'b1) begin
                start = 1'b1; sent = 1'b1;
                @(negedge Clk); cyc++;
                start = 1'b0;
            end
        end
        check({tag, ":done_seen"}, done, 1);
        if (e_err != 0) check({tag, ":err_latency"}, cyc, 3);
        check({tag, ":err"}, err, e_err);
        check({tag, ":converged"}, converged, e_conv);
        check({tag, ":iter_count"}, iter_count, e_iter);
        check({tag, ":num_vals"}, num_vals, nv & 16'hFFFF);
        check({tag, ":num_clusters"}, num_clusters, nc & 16'hFFFF);
        check({tag, ":num_dims"}, num_dims, nd & 16'hFFFF);
        check({tag, ":n_assign"}, n_as - as0, e_as);
        check({tag, ":n_update"}, n_us - us0, e_us);
        check({tag, ":n_copy"}, n_cs - cs0, e_cs);
        check({tag, ":ready_at_done"}, ready, 0);
        @(negedge Clk);
        check({tag, ":ready_after"}, ready, 1);
        check({tag, ":done_pulse"}, done, 0);
    endtask

    initial begin : main
        int nv, nc, nd, k, cyc, as0, us0, cs0, d0;
        for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
        for (int i = 0; i < MAX_ITER; i++) chg_tab[i] = 1'b1;
        RESET = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst:ready", ready, 1);
        check("rst:done", done, 0);
        check("rst:err", err, 0);
        check("rst:converged", converged, 0);
        check("rst:iter_count", iter_count, 0);
        check("rst:bram_addr", bram_addr, 0);
        check("rst:starts", {assign_start, update_start, copy_start}, 0);
        check("rst:cfg", {num_vals, num_clusters, num_dims}, 0);
        @(posedge Clk); #1;
        RESET = 1'b0;

        for (int i = 0; i < MAX_ITER; i++) chg_tab[i] = 1'b0;
        chg_tab[0] = 1'b1; chg_tab[1] = 1'b1;
        run_job("conv3", 100, 4, 2, 1'b1);
        for (int i = 0; i < MAX_ITER; i++) chg_tab[i] = 1'b1;
        run_job("maxiter", 100, 4, 2, 1'b0);
        for (int i = 0; i < MAX_ITER; i++) chg_tab[i] = 1'b0;
        run_job("seed_nochg", 100, 4, 2, 1'b0);
        run_job("nc_zero", 100, 0, 2, 1'b0);
        run_job("nv_big", 3000, 4, 2, 1'b0);
        run_job("nc_gt_nv", 4, 5, 2, 1'b0);
        run_job("nd_zero", 10, 2, 0, 1'b0);
        run_job("nv_zero", 0, 1, 1, 1'b0);
        run_job("nv_2049", 2049, 3, 1, 1'b0);
        fill_chg(70);
        run_job("nv_2048", 2048, 2048, 1, 1'b0);

        for (int j = 0; j < 8; j++) begin
            nv = $urandom_range(1, 2048);
            nc = $urandom_range(1, (nv > 16) ? 16 : nv);
            nd = $urandom_range(1, 8);
            k = $urandom_range(0, 9);
            if (k == 0) nc = 0;
            else if (k == 1) nd = 0;
            else if (k == 2) nv = $urandom_range(2049, 4000);
            else if (k == 3) nc = nv + 1;
            fill_chg(85);
            run_job($sformatf("rand%0d", j), nv, nc, nd, 1'b0);
        end

        // Reset while waiting on the update engine, then a clean rerun.
        for (int i = 0; i < MAX_ITER; i++) chg_tab[i] = 1'b1;
        mem[0] = 16'h0064; mem[1] = 16'h0004; mem[2] = 16'h0002;
        job_id++;
        hold_upd = 1'b1;
        @(posedge Clk); #1;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        cyc = 0;
        while (update_start !== 1'b1 && cyc < 200) begin @(negedge Clk); cyc++; end
        check("rstmid:reach_uwait", update_start, 1);
        @(negedge Clk);
        RESET = 1'b1;
        #1;
        check("rstmid:ready", ready, 1);
        check("rstmid:done", done, 0);
        check("rstmid:err", err, 0);
        check("rstmid:converged", converged, 0);
        check("rstmid:iter_count", iter_count, 0);
        check("rstmid:bram_addr", bram_addr, 0);
        check("rstmid:starts", {assign_start, update_start, copy_start}, 0);
        check("rstmid:cfg", {num_vals, num_clusters, num_dims}, 0);
        repeat (2) @(posedge Clk);
        #1;
        RESET = 1'b0;
        hold_upd = 1'b0;
        as0 = n_as; us0 = n_us; cs0 = n_cs; d0 = n_done;
        repeat (10) @(negedge Clk);
        check("rstmid:quiet_pulses", (n_as - as0) + (n_us - us0) + (n_cs - cs0), 0);
        check("rstmid:quiet_done", n_done - d0, 0);
        check("rstmid:ready_after", ready, 1);
        for (int i = 0; i < MAX_ITER; i++) chg_tab[i] = 1'b0;
        chg_tab[0] = 1'b1; chg_tab[1] = 1'b1;
        run_job("after_rst", 100, 4, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/kmeans_sched.md
Name: kmeans_sched

Overview:
- Top-level iteration sequencer for the k-means engine.
- On start, reads the config words (NUM_VALS, NUM_CLUSTERS, NUM_DIMS) from PNL BRAM addresses 0/1/2 and validates them.
- Then runs assign → update passes until assignments stop changing or the iteration limit is hit.
- Finally triggers the copy of clusters to FINAL_CLUSTER_BASE_ADDR. It owns only the BRAM config-read phase; the sub-engines own the BRAM otherwise.

Parameters:
- ADDR_NB, 15, PNL BRAM address width.
- DATA_NB, 16, PNL BRAM word width.
- MAX_ITER, 100, maximum assign passes.
- MAX_VALS, 2048, largest legal NUM_VALS (ARRAY_SIZE).
- TIMEOUT_CYC, 2**20, watchdog limit per wait state (only used with the optional feature).

Ports:
- Clk  in  1  clock
- RESET  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; ignored unless ready=1
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse on completion or abort
- err  out  1  sticky config/timeout error; cleared on accepted start
- converged  out  1  valid with done; 1 if exited on no-change
- iter_count  out  7  completed assign passes
- bram_addr  out  ADDR_NB  config read address
- bram_din  in  DATA_NB  BRAM read data, 1-cycle latency
- num_vals, num_clusters, num_dims  out  DATA_NB each  registered config to engines
- assign_start  out  1  one-cycle pulse
- assign_done  in  1  one-cycle pulse
- assign_changed  in  1  sampled with assign_done; any point changed cluster
- update_start  out  1  one-cycle pulse
- update_done  in  1  one-cycle pulse
- copy_start  out  1  one-cycle pulse
- copy_done  in  1  one-cycle pulse

Behaviour:
- Reset values:
  - ready=1; all other outputs 0.
  - State IDLE.
  - Asynchronous reset mid-operation returns to IDLE within the reset cycle; no pulses are issued afterwards.
- States: IDLE, RD_CFG0, RD_CFG1, RD_CFG2, RD_CFG3, CHK, A_WAIT, U_WAIT, C_WAIT, FIN.
- IDLE: start=1 → clear err, converged, iter_count; bram_addr=0; go to RD_CFG0.
- RD_CFG0..2: bram_addr steps 1, then 2. Data is captured one cycle after its address:
  - num_vals in RD_CFG1;
  - num_clusters in RD_CFG2;
  - num_dims in RD_CFG3.
  - RD_CFG3 → CHK.
- CHK: error if any of the following:
  - num_clusters==0;
  - num_dims==0;
  - num_vals==0;
  - num_clusters>num_vals;
  - num_vals>MAX_VALS.
  - On error: set err, go to FIN with converged=0.
  - Otherwise: pulse assign_start, go to A_WAIT.
- A_WAIT: on assign_done → iter_count+1.
  - If assign_changed=0 and iter_count(before increment)≥1: converged=1, pulse copy_start, go to C_WAIT.
  - Else if iter_count+1==MAX_ITER: converged=0, pulse copy_start, go to C_WAIT.
  - Else: pulse update_start, go to U_WAIT.
  - The first pass always runs update, because initial centroids are seeds.
- U_WAIT: on update_done → pulse assign_start, go to A_WAIT.
- C_WAIT: on copy_done → FIN.
- FIN: pulse done, go to IDLE. ready=1 from the following cycle.
- Handshake and pulse rules:
  - Start pulses are registered, one cycle wide, and issued in the cycle after the triggering event.
  - done inputs arriving in a state not waiting for them are ignored.
  - start while ready=0 is ignored.
- iter_count saturates; it never exceeds MAX_ITER.

Optional Feature:
- Macro KMEANS_SCHED_TIMEOUT_EN.
- When defined:
  - A 21-bit watchdog resets on entry to each of A_WAIT, U_WAIT and C_WAIT, and increments each cycle in them.
  - On reaching TIMEOUT_CYC: set err, converged=0, go to FIN. No further engine pulses.
- When undefined: no watchdog logic; wait states wait indefinitely.

Test Plan:
- Config 100/4/2; engine reports changed=1,1,0 → 3 assign_start, 2 update_start, 1 copy_start; done with converged=1, iter_count=3, err=0.
- Config 100/4/2; changed always 1 → 100 assign passes, 99 updates; done with converged=0, iter_count=100.
- Config num_clusters=0 (and separately num_vals=3000, num_clusters=5>num_vals=4) → no assign_start; done within 6 cycles of start; err=1.
- Config read timing: bram_addr 0,1,2 on consecutive cycles; outputs latch the BRAM words 0x0064/0x0004/0x0002 correctly; start pulsed during A_WAIT is ignored.
- Assert RESET during U_WAIT → ready=1 and all outputs 0 immediately; a later start runs a full clean sequence.
- With KMEANS_SCHED_TIMEOUT_EN, TIMEOUT_CYC=64, update_done withheld → done pulse 64 cycles after U_WAIT entry; err=1, converged=0.
